winograd_output_mesh: RTL and testbench
=======================================

// Module: winograd_output_mesh
// PURPOSE
//  Output-side counterpart of the Winograd F(2x2,3x3) input-transform mesh.
//  - Accepts MESH_N element-wise-product tiles (4x4) per beat.
//  - Accumulates the tiles over input channels until a beat marked in_last.
//  - Applies Y = A^T*M*A and emits MESH_N 2x2 output tiles over a valid/ready stream.
// PARAMETERS
//  MESH_N       8             tiles processed in parallel per beat
//  TILE_SIZE    4             transformed tile edge (fixed 4 for F(2x2,3x3))
//  OUT_SIZE     2             output tile edge (fixed 2)
//  PROD_BIT     18            signed width of each product element
//  ACC_BIT      PROD_BIT+8    signed accumulator width (up to 256 channels without overflow)
//  RESULT_BIT   ACC_BIT+4     signed output element width (+2 bits per transform pass)
// PORTS
//  clk        in   1                        rising-edge clock
//  rst_n      in   1                        asynchronous active-low reset
//  in_valid   in   1                        product beat valid
//  in_ready   out  1                        beat accepted when in_valid & in_ready
//  in_last    in   1                        beat is the final channel of the tile group
//  prod       in   MESH_N*16*PROD_BIT       tile i at [16*PROD_BIT*(i+1)-1 : 16*PROD_BIT*i]
//                                           element (r,c) at offset (4r+c)*PROD_BIT
//  out_valid  out  1                        result valid
//  out_ready  in   1                        downstream accepts result
//  result     out  MESH_N*4*RESULT_BIT      tile i, element (r,c) at offset (2r+c)*RESULT_BIT
//  acc_busy   out  1                        accumulator holds a partial (non-last) sum
// BEHAVIOUR
//  Reset: clears all registers, all valid bits, acc_busy and the accumulators.
//    out_valid=0, result=0, in_ready=1.
//  Pipeline enable: en = ~out_valid | out_ready. in_ready = en. All stages advance only when en=1.
//  Stage ACC, on an accepted beat:
//    - in_last=0: acc <= acc + sext(prod); acc_busy <= 1.
//    - in_last=1: tile_reg <= acc + sext(prod); acc <= 0; acc_busy <= 0; v1 <= 1.
//    - No beat accepted while en=1: v1 <= 0.
//  Stage ROW (en=1): T = A^T*tile_reg; v2 <= v1.
//    T[0][j] = M0j+M1j+M2j;  T[1][j] = M1j-M2j-M3j.
//  Stage COL (en=1): Y = T*A; result <= Y; out_valid <= v2.
//    Y[i][0] = Ti0+Ti1+Ti2;  Y[i][1] = Ti1-Ti2-Ti3.
//  Latency: last beat accepted at cycle k -> out_valid=1 at k+3 when unstalled.
//    Throughput is one tile group per cycle (single-beat groups back to back).
//  Stall: out_valid=1 & out_ready=0 freezes every stage, acc and acc_busy.
//    result is held stable; in_ready=0, so no beat is lost or double-counted.
//  Arithmetic: two's complement throughout; sign-extend before add; no saturation.
//    Accumulator overflow beyond ACC_BIT wraps. Keeping it in range is the caller's duty.
//  Single-beat group (in_last on first beat): result is the transform of prod alone.
//  in_valid=0 cycles inside a group leave acc unchanged; the group may span idle cycles.
//  Reset asserted mid-group discards the partial sum and all in-flight results.
// STRUCTURE
//  Shared package winograd_pkg:
//    - F(2x2,3x3) A^T coefficient table and TILE_SIZE/OUT_SIZE constants.
//    - Width helper functions for RESULT_BIT, shared with the input-side mesh.
//  Sub-module winograd_output_tile (one per mesh lane, generate loop MESH_N):
//    - Holds acc, tile_reg, T and Y registers for one tile, driven by a shared en/v1/v2.
//  Top level holds only the handshake: en, valid chain and acc_busy.
// TESTING (PROD_BIT=8, ACC_BIT=16, MESH_N=2 unless stated)
//  1. Single beat, all prod=1, in_last=1, out_ready=1 -> at +3 cycles every tile Y = {9,-3,-3,1}.
//  2. Delta tile M[1][1]=5, rest 0, single beat -> Y = {5,5,5,5}; other lane zeros -> Y = {0,0,0,0}.
//  3. Three beats of all-ones, last on beat 3, with an idle cycle between beats 1 and 2
//     -> Y = {27,-9,-9,3}; acc_busy=1 after beat 1 until beat 3.
//  4. Back-to-back single-beat groups of values 1,2,3 with out_ready low for 5 cycles after the first result
//     -> result held at {9,-3,-3,1}; in_ready=0 during the stall; then {18,-6,-6,2} and {27,-9,-9,3} in order.
//  5. All prod=-128, single beat -> Y = {-1152,384,384,-128}; checks sign extension.
//  6. Two non-last beats of all-ones, then rst_n low for 1 cycle, then a single all-ones last beat
//     -> Y = {9,-3,-3,1}, with no residue from the discarded partial sum.

Source files
------------

// File: rtl/winograd_pkg.sv
// Shared Winograd F(2x2,3x3) constants, transform coefficients and width helpers.
// Used by both the input-side and output-side transform meshes.
package winograd_pkg;

    localparam int TILE_SIZE  = 4;
    localparam int OUT_SIZE   = 2;
    localparam int TILE_ELEMS = TILE_SIZE * TILE_SIZE;
    localparam int OUT_ELEMS  = OUT_SIZE * OUT_SIZE;

    typedef logic signed [1:0] coef_t;

    localparam coef_t C_ZERO = 2'sb00;
    localparam coef_t C_POS  = 2'sb01;
    localparam coef_t C_NEG  = 2'sb11;

    // A^T for F(2x2,3x3); the column pass uses the same table transposed
    localparam coef_t AT_COEF [OUT_SIZE][TILE_SIZE] = '{
        '{C_POS,  C_POS, C_POS, C_ZERO},
        '{C_ZERO, C_POS, C_NEG, C_NEG }
    };

    function automatic int row_pass_bits(input int acc_bit);
        return acc_bit + 2;
    endfunction

    function automatic int result_bits(input int acc_bit);
        return acc_bit + 4;
    endfunction

endpackage

// File: rtl/winograd_output_tile.sv
// One mesh lane: channel accumulator, captured tile, row pass T and column pass Y.
// All state advances only on the shared pipeline enable.
module winograd_output_tile
    import winograd_pkg::*;
#(
    parameter int PROD_BIT   = 18,
    parameter int ACC_BIT    = PROD_BIT + 8,
    parameter int RESULT_BIT = ACC_BIT + 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en,
    input  logic                           take,
    input  logic                           last,
    input  logic [TILE_ELEMS*PROD_BIT-1:0] prod_i,
    output logic [OUT_ELEMS*RESULT_BIT-1:0] result_o
);

    localparam int T_BIT = row_pass_bits(ACC_BIT);

    logic signed [PROD_BIT-1:0]   prod_s [TILE_ELEMS];
    logic signed [ACC_BIT-1:0]    sum_s  [TILE_ELEMS];
    logic signed [ACC_BIT-1:0]    acc_q  [TILE_ELEMS];
    logic signed [ACC_BIT-1:0]    acc_d  [TILE_ELEMS];
    logic signed [ACC_BIT-1:0]    tile_q [TILE_ELEMS];
    logic signed [ACC_BIT-1:0]    tile_d [TILE_ELEMS];
    logic signed [T_BIT-1:0]      t_q    [OUT_SIZE*TILE_SIZE];
    logic signed [T_BIT-1:0]      t_d    [OUT_SIZE*TILE_SIZE];
    logic signed [RESULT_BIT-1:0] y_q    [OUT_ELEMS];
    logic signed [RESULT_BIT-1:0] y_d    [OUT_ELEMS];

    always_comb begin
        for (int e = 0; e < TILE_ELEMS; e++) begin
            prod_s[e] = prod_i[e*PROD_BIT +: PROD_BIT];
            sum_s[e]  = acc_q[e] + ACC_BIT'(prod_s[e]);
            acc_d[e]  = acc_q[e];
            tile_d[e] = tile_q[e];
            if (take) begin
                if (last) begin
                    acc_d[e]  = '0;
                    tile_d[e] = sum_s[e];
                end else begin
                    acc_d[e] = sum_s[e];
                end
            end
        end
    end

    // Row pass: T = A^T * M
    always_comb begin
        for (int i = 0; i < OUT_SIZE; i++) begin
            for (int j = 0; j < TILE_SIZE; j++) begin
                t_d[i*TILE_SIZE+j] = '0;
                for (int k = 0; k < TILE_SIZE; k++) begin
                    unique case (1'b1)
                        (AT_COEF[i][k] == C_POS):
                            t_d[i*TILE_SIZE+j] = t_d[i*TILE_SIZE+j]
                                + T_BIT'(tile_q[k*TILE_SIZE+j]);
                        (AT_COEF[i][k] == C_NEG):
                            t_d[i*TILE_SIZE+j] = t_d[i*TILE_SIZE+j]
                                - T_BIT'(tile_q[k*TILE_SIZE+j]);
                        default: ;
                    endcase
                end
            end
        end
    end

    // Column pass: Y = T * A, i.e. Y[i][j] = sum_k T[i][k] * A^T[j][k]
    always_comb begin
        for (int i = 0; i < OUT_SIZE; i++) begin
            for (int j = 0; j < OUT_SIZE; j++) begin
                y_d[i*OUT_SIZE+j] = '0;
                for (int k = 0; k < TILE_SIZE; k++) begin
                    unique case (1'b1)
                        (AT_COEF[j][k] == C_POS):
                            y_d[i*OUT_SIZE+j] = y_d[i*OUT_SIZE+j]
                                + RESULT_BIT'(t_q[i*TILE_SIZE+k]);
                        (AT_COEF[j][k] == C_NEG):
                            y_d[i*OUT_SIZE+j] = y_d[i*OUT_SIZE+j]
                                - RESULT_BIT'(t_q[i*TILE_SIZE+k]);
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < TILE_ELEMS; e++) begin
                acc_q[e]  <= '0;
                tile_q[e] <= '0;
            end
            for (int e = 0; e < OUT_SIZE*TILE_SIZE; e++) begin
                t_q[e] <= '0;
            end
            for (int e = 0; e < OUT_ELEMS; e++) begin
                y_q[e] <= '0;
            end
        end else if (en) begin
            for (int e = 0; e < TILE_ELEMS; e++) begin
                acc_q[e]  <= acc_d[e];
                tile_q[e] <= tile_d[e];
            end
            for (int e = 0; e < OUT_SIZE*TILE_SIZE; e++) begin
                t_q[e] <= t_d[e];
            end
            for (int e = 0; e < OUT_ELEMS; e++) begin
                y_q[e] <= y_d[e];
            end
        end
    end

    always_comb begin
        for (int e = 0; e < OUT_ELEMS; e++) begin
            result_o[e*RESULT_BIT +: RESULT_BIT] = y_q[e];
        end
    end

endmodule

// File: rtl/winograd_output_mesh.sv
// Winograd F(2x2,3x3) output transform mesh: channel accumulation plus A^T*M*A.
// Top level owns the stream handshake; lanes hold the datapath.
module winograd_output_mesh
    import winograd_pkg::*;
#(
    parameter int MESH_N     = 8,
    parameter int PROD_BIT   = 18,
    parameter int ACC_BIT    = PROD_BIT + 8,
    parameter int RESULT_BIT = result_bits(ACC_BIT)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic                                  in_last,
    input  logic [MESH_N*TILE_ELEMS*PROD_BIT-1:0] prod,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [MESH_N*OUT_ELEMS*RESULT_BIT-1:0] result,
    output logic                                  acc_busy
);

    logic en;
    logic fire;
    logic v1_q, v1_d;
    logic v2_q, v2_d;
    logic ov_q, ov_d;
    logic busy_q, busy_d;

    // A held result freezes the whole pipe, so nothing upstream can move
    assign en   = ~ov_q | out_ready;
    assign fire = in_valid & en;

    always_comb begin
        v1_d   = v1_q;
        v2_d   = v2_q;
        ov_d   = ov_q;
        busy_d = busy_q;
        if (en) begin
            v1_d = fire & in_last;
            v2_d = v1_q;
            ov_d = v2_q;
        end
        if (fire) begin
            busy_d = ~in_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            ov_q   <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            ov_q   <= ov_d;
            busy_q <= busy_d;
        end
    end

    assign in_ready  = en;
    assign out_valid = ov_q;
    assign acc_busy  = busy_q;

    for (genvar g = 0; g < MESH_N; g++) begin : g_lane
        winograd_output_tile #(
            .PROD_BIT  (PROD_BIT),
            .ACC_BIT   (ACC_BIT),
            .RESULT_BIT(RESULT_BIT)
        ) u_tile (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en),
            .take    (fire),
            .last    (in_last),
            .prod_i  (prod[g*TILE_ELEMS*PROD_BIT +: TILE_ELEMS*PROD_BIT]),
            .result_o(result[g*OUT_ELEMS*RESULT_BIT +: OUT_ELEMS*RESULT_BIT])
        );
    end

endmodule

// File: tb/tb_winograd_output_mesh.sv
// Scoreboard bench for winograd_output_mesh: directed cases plus random groups
// checked against an integer matrix reference model.
module tb_winograd_output_mesh;

    localparam int MESH_N = 2;
    localparam int PROD_BIT = 8;
    localparam int ACC_BIT = 16;
    localparam int RESULT_BIT = 20;
    localparam int PW = MESH_N * 16 * PROD_BIT;
    localparam int RW = MESH_N * 4 * RESULT_BIT;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid, in_ready, in_last;
    logic out_valid, out_ready, acc_busy;
    logic [PW-1:0] prod;
    logic [RW-1:0] result;

    always #5 clk = ~clk;

    winograd_output_mesh #(
        .MESH_N    (MESH_N),
        .PROD_BIT  (PROD_BIT),
        .ACC_BIT   (ACC_BIT),
        .RESULT_BIT(RESULT_BIT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_last  (in_last),
        .prod     (prod),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .acc_busy (acc_busy)
    );

    int nvec = 0;
    int nbad = 0;
    logic [RW-1:0] expq[$];
    int macc[MESH_N][16];
    int cur[MESH_N][16];

    task automatic check(string name, logic [RW-1:0] act, logic [RW-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: Y = A^T * M * A with M the channel sum, in plain integers
    function automatic logic [RW-1:0] model_out();
        logic [RW-1:0] r = '0;
        for (int l = 0; l < MESH_N; l++) begin
            int m[4][4];
            int t[2][4];
            int y[2][2];
            for (int e = 0; e < 16; e++) m[e/4][e%4] = macc[l][e];
            for (int j = 0; j < 4; j++) begin
                t[0][j] = m[0][j] + m[1][j] + m[2][j];
                t[1][j] = m[1][j] - m[2][j] - m[3][j];
            end
            for (int i = 0; i < 2; i++) begin
                y[i][0] = t[i][0] + t[i][1] + t[i][2];
                y[i][1] = t[i][1] - t[i][2] - t[i][3];
            end
            for (int e = 0; e < 4; e++)
                r[(l*4+e)*RESULT_BIT +: RESULT_BIT] = RESULT_BIT'(y[e/2][e%2]);
        end
        return r;
    endfunction

    function automatic logic [RW-1:0] const_tile(int a, int b, int c, int d);
        logic [RW-1:0] r = '0;
        for (int l = 0; l < MESH_N; l++) begin
            r[(l*4+0)*RESULT_BIT +: RESULT_BIT] = RESULT_BIT'(a);
            r[(l*4+1)*RESULT_BIT +: RESULT_BIT] = RESULT_BIT'(b);
            r[(l*4+2)*RESULT_BIT +: RESULT_BIT] = RESULT_BIT'(c);
            r[(l*4+3)*RESULT_BIT +: RESULT_BIT] = RESULT_BIT'(d);
        end
        return r;
    endfunction

    task automatic model_clear();
        for (int l = 0; l < MESH_N; l++)
            for (int e = 0; e < 16; e++) macc[l][e] = 0;
    endtask

    task automatic fill(int v);
        for (int l = 0; l < MESH_N; l++)
            for (int e = 0; e < 16; e++) cur[l][e] = v;
    endtask

    // Presents one beat from cur; returns at posedge+1 after acceptance
    task automatic beat(bit last);
        int n = 0;
        for (int l = 0; l < MESH_N; l++)
            for (int e = 0; e < 16; e++)
                prod[(l*16+e)*PROD_BIT +: PROD_BIT] = PROD_BIT'(cur[l][e]);
        in_valid = 1'b1;
        in_last = last;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            nvec++;
            nbad++;
            $display("FAIL beat_timeout: in_ready stuck at 0 for %0d cycles", n);
        end else begin
            @(posedge clk);
            for (int l = 0; l < MESH_N; l++)
                for (int e = 0; e < 16; e++) macc[l][e] += cur[l][e];
            if (last) begin
                expq.push_back(model_out());
                model_clear();
            end
        end
        #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (expq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (expq.size() != 0) begin
            nvec++;
            nbad++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", expq.size());
            expq.delete();
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (expq.size() == 0) begin
                nvec++;
                nbad++;
                $display("FAIL unexpected_result: got %h with empty scoreboard", result);
            end else begin
                check("result", result, expq.pop_front());
            end
        end
    end

    bit done;

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        prod = '0;
        out_ready = 1'b1;
        model_clear();
        @(negedge clk);
        check("rst_out_valid", RW'(out_valid), RW'(0));
        check("rst_result", result, '0);
        check("rst_in_ready", RW'(in_ready), RW'(1));
        check("rst_acc_busy", RW'(acc_busy), RW'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: all ones, single beat, plus latency
        fill(1);
        beat(1'b1);
        @(negedge clk);
        check("lat_k1", RW'(out_valid), RW'(0));
        @(negedge clk);
        check("lat_k2", RW'(out_valid), RW'(0));
        @(negedge clk);
        check("lat_k3", RW'(out_valid), RW'(1));
        check("ones_const", result, const_tile(9, -3, -3, 1));
        drain();

        // 2: delta tile on lane 0, zeros on lane 1
        fill(0);
        cur[0][5] = 5;
        beat(1'b1);
        drain();

        // 3: three beats with an idle gap
        fill(1);
        beat(1'b0);
        @(negedge clk);
        check("busy_b1", RW'(acc_busy), RW'(1));
        @(posedge clk);
        #1;
        beat(1'b0);
        @(negedge clk);
        check("busy_b2", RW'(acc_busy), RW'(1));
        @(posedge clk);
        #1;
        beat(1'b1);
        @(negedge clk);
        check("busy_b3", RW'(acc_busy), RW'(0));
        drain();

        // 4: back-to-back groups under a stall
        out_ready = 1'b0;
        fork
            begin
                fill(1);
                beat(1'b1);
                fill(2);
                beat(1'b1);
                fill(3);
                beat(1'b1);
            end
            begin
                int n = 0;
                @(negedge clk);
                while (!out_valid && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                for (int s = 0; s < 5; s++) begin
                    check("stall_hold", result, const_tile(9, -3, -3, 1));
                    check("stall_in_ready", RW'(in_ready), RW'(0));
                    @(negedge clk);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // 5: sign extension
        fill(-128);
        beat(1'b1);
        drain();

        // 6: reset mid-group
        fill(1);
        beat(1'b0);
        beat(1'b0);
        rst_n = 1'b0;
        expq.delete();
        model_clear();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_busy", RW'(acc_busy), RW'(0));
        @(posedge clk);
        #1;
        beat(1'b1);
        drain();

        // Random groups with random backpressure
        done = 1'b0;
        fork
            begin
                for (int g = 0; g < 40; g++) begin
                    int len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++) begin
                        for (int l = 0; l < MESH_N; l++)
                            for (int e = 0; e < 16; e++)
                                cur[l][e] = int'($urandom_range(0, 255)) - 128;
                        beat(b == len - 1);
                        if ($urandom_range(0, 3) == 0) begin
                            @(posedge clk);
                            #1;
                        end
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
